// File: rtl/ins_cache.sv
// Direct-mapped instruction cache, one 32-bit word per line, with a single outstanding miss.
// Optional hit/miss statistics counters are built when INS_CACHE_STATS_EN is defined.
module ins_cache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        pc_valid,
    input  logic [31:0] pc,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic        is_fetch,
    output logic [31:0] fetch_addr,
    input  logic        is_back,
    input  logic [31:0] back_ins,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [LINES-1:0]         valid_r;
    logic [TAG_W-1:0]         tag_r  [LINES];
    logic [31:0]              data_r [LINES];
    logic [TAG_W-1:0]         miss_tag_r;
    logic [INDEX_WIDTH-1:0]   miss_idx_r;
    logic [INDEX_WIDTH-1:0]   idx_s;
    logic [TAG_W-1:0]         tag_s;
    logic                     hit_s;
    logic                     start_miss_s;
    logic                     fill_s;
    logic                     is_fetch_r;
    logic [31:0]              fetch_addr_r;
    logic                     unused_s;

    assign idx_s    = pc[INDEX_WIDTH+1:2];
    assign tag_s    = pc[31:INDEX_WIDTH+2];
    assign hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign unused_s = ^pc[1:0];

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a stalled cycle holds and a flush always returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        if (!rdy_in) begin
            state_nxt_s = state_r;
        end else if (rob_clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_miss_s) begin
                        state_nxt_s = ST_MISS;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MISS: begin
                    if (is_back) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_MISS;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: same-cycle hit, miss launch and fill strobes
    always_comb begin
        ins_ready    = 1'b0;
        ins          = data_r[idx_s];
        start_miss_s = 1'b0;
        fill_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rdy_in && !rob_clear && pc_valid) begin
                    ins_ready    = hit_s;
                    start_miss_s = !hit_s;
                end else begin
                    ins_ready    = 1'b0;
                    start_miss_s = 1'b0;
                end
            end
            ST_MISS: begin
                if (rdy_in && !rob_clear && is_back) begin
                    fill_s = 1'b1;
                end else begin
                    fill_s = 1'b0;
                end
            end
            default: begin
                ins_ready    = 1'b0;
                start_miss_s = 1'b0;
                fill_s       = 1'b0;
            end
        endcase
    end

    // Memory request registers; address frozen for the whole miss
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            is_fetch_r   <= 1'b0;
            fetch_addr_r <= 32'd0;
            miss_tag_r   <= {TAG_W{1'b0}};
            miss_idx_r   <= {INDEX_WIDTH{1'b0}};
        end else if (rdy_in) begin
            if (rob_clear || fill_s) begin
                is_fetch_r <= 1'b0;
            end else if (start_miss_s) begin
                is_fetch_r   <= 1'b1;
                fetch_addr_r <= {pc[31:2], 2'b00};
                miss_tag_r   <= tag_s;
                miss_idx_r   <= idx_s;
            end else begin
                is_fetch_r <= is_fetch_r;
            end
        end
    end

    assign is_fetch   = is_fetch_r;
    assign fetch_addr = fetch_addr_r;

    // Valid bits are the only line state cleared by reset
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_r <= {LINES{1'b0}};
        end else if (fill_s) begin
            valid_r[miss_idx_r] <= 1'b1;
        end
    end

    // Tag and data storage; a fill simply overwrites the indexed line
    always_ff @(posedge clk_in) begin
        if (fill_s) begin
            tag_r[miss_idx_r]  <= miss_tag_r;
            data_r[miss_idx_r] <= back_ins;
        end
    end

`ifdef INS_CACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Statistics counters, wrapping naturally at 2^32
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (ins_ready) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (start_miss_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ins_cache.sv
// Directed self-checking bench for ins_cache: hits, misses, eviction, flush, stall, reset, statistics.
module tb_ins_cache;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        pc_valid;
    logic [31:0] pc;
    logic        ins_ready;
    logic [31:0] ins;
    logic        is_fetch;
    logic [31:0] fetch_addr;
    logic        is_back;
    logic [31:0] back_ins;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    ins_cache #(.INDEX_WIDTH(6)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .pc_valid   (pc_valid),
        .pc         (pc),
        .ins_ready  (ins_ready),
        .ins        (ins),
        .is_fetch   (is_fetch),
        .fetch_addr (fetch_addr),
        .is_back    (is_back),
        .back_ins   (back_ins),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n_in  = 1'b0;
        rdy_in    = 1'b1;
        rob_clear = 1'b0;
        pc_valid  = 1'b0;
        pc        = 32'd0;
        is_back   = 1'b0;
        back_ins  = 32'd0;
        #12;
        chk("rst_is_fetch", {31'd0, is_fetch}, 32'd0);
        chk("rst_fetch_addr", fetch_addr, 32'd0);
        chk("rst_ins_ready", {31'd0, ins_ready}, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        rst_n_in = 1'b1;
        tick();

        // Cold miss on 0x1000, two-cycle memory latency
        pc_valid = 1'b1;
        pc = 32'h0000_1000;
        #1;
        chk("cold_ins_ready", {31'd0, ins_ready}, 32'd0);
        tick();
        chk("cold_is_fetch", {31'd0, is_fetch}, 32'd1);
        chk("cold_fetch_addr", fetch_addr, 32'h0000_1000);
        chk("miss_ins_ready", {31'd0, ins_ready}, 32'd0);
        pc = 32'h0000_3008;
        tick();
        chk("pc_chg_fetch_addr", fetch_addr, 32'h0000_1000);
        chk("pc_chg_is_fetch", {31'd0, is_fetch}, 32'd1);
        pc = 32'h0000_1000;
        is_back = 1'b1;
        back_ins = 32'h0000_0013;
        tick();
        is_back = 1'b0;
        back_ins = 32'hFFFF_FFFF;
        #1;
        chk("fill_ins_ready", {31'd0, ins_ready}, 32'd1);
        chk("fill_ins", ins, 32'h0000_0013);
        chk("fill_is_fetch", {31'd0, is_fetch}, 32'd0);
        pc = 32'h0000_1003;
        #1;
        chk("low_bits_ignored", {31'd0, ins_ready}, 32'd1);

        // Conflict miss on index 0 evicts 0x1000
        pc = 32'h0000_1100;
        #1;
        chk("conflict_ins_ready", {31'd0, ins_ready}, 32'd0);
        tick();
        chk("conflict_fetch_addr", fetch_addr, 32'h0000_1100);
        is_back = 1'b1;
        back_ins = 32'h00A0_0093;
        tick();
        is_back = 1'b0;
        #1;
        chk("conflict_ins_ready2", {31'd0, ins_ready}, 32'd1);
        chk("conflict_ins", ins, 32'h00A0_0093);
        pc = 32'h0000_1000;
        #1;
        chk("evicted_ins_ready", {31'd0, ins_ready}, 32'd0);
        tick();
        chk("evicted_is_fetch", {31'd0, is_fetch}, 32'd1);
        chk("evicted_fetch_addr", fetch_addr, 32'h0000_1000);
        is_back = 1'b1;
        back_ins = 32'h0000_0013;
        tick();
        is_back = 1'b0;
        #1;
        chk("refill_ins", ins, 32'h0000_0013);
        rdy_in = 1'b0;
        #1;
        chk("stall_hit_blocked", {31'd0, ins_ready}, 32'd0);
        rdy_in = 1'b1;
        rob_clear = 1'b1;
        #1;
        chk("flush_hit_blocked", {31'd0, ins_ready}, 32'd0);
        rob_clear = 1'b0;

        // Flush together with the returning word: no fill
        pc = 32'h0000_2004;
        tick();
        chk("flush_fetch_addr", fetch_addr, 32'h0000_2004);
        rob_clear = 1'b1;
        is_back = 1'b1;
        back_ins = 32'hDEAD_BEEF;
        tick();
        rob_clear = 1'b0;
        is_back = 1'b0;
        #1;
        chk("flush_is_fetch", {31'd0, is_fetch}, 32'd0);
        chk("flush_no_fill", {31'd0, ins_ready}, 32'd0);
        tick();
        chk("flush_remiss", {31'd0, is_fetch}, 32'd1);

        // Stall for three cycles with is_back pulsed: nothing moves
        rdy_in = 1'b0;
        is_back = 1'b1;
        back_ins = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_is_fetch", {31'd0, is_fetch}, 32'd1);
            chk("stall_fetch_addr", fetch_addr, 32'h0000_2004);
        end
        rdy_in = 1'b1;
        is_back = 1'b0;
        tick();
        chk("post_stall_is_fetch", {31'd0, is_fetch}, 32'd1);
        chk("post_stall_ins_ready", {31'd0, ins_ready}, 32'd0);
        is_back = 1'b1;
        back_ins = 32'h2222_2222;
        tick();
        is_back = 1'b0;
        #1;
        chk("post_stall_fill", ins, 32'h2222_2222);
        chk("post_stall_hit", {31'd0, ins_ready}, 32'd1);

        // Asynchronous reset in the middle of a miss
        pc = 32'h0000_1000;
        #1;
        chk("pre_rst_hit", {31'd0, ins_ready}, 32'd1);
        pc = 32'h0000_3000;
        tick();
        chk("pre_rst_is_fetch", {31'd0, is_fetch}, 32'd1);
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_is_fetch", {31'd0, is_fetch}, 32'd0);
        chk("async_rst_fetch_addr", fetch_addr, 32'd0);
        rst_n_in = 1'b1;
        pc = 32'h0000_1000;
        #1;
        chk("post_rst_miss", {31'd0, ins_ready}, 32'd0);
        tick();
        chk("post_rst_is_fetch", {31'd0, is_fetch}, 32'd1);
        chk("post_rst_fetch_addr", fetch_addr, 32'h0000_1000);

        // Statistics: two misses then five hit cycles from a fresh reset
        pc_valid = 1'b0;
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
        tick();
        pc_valid = 1'b1;
        pc = 32'h0000_4000;
        tick();
        is_back = 1'b1;
        back_ins = 32'h0000_0AAA;
        tick();
        is_back = 1'b0;
        pc = 32'h0000_4008;
        tick();
        is_back = 1'b1;
        back_ins = 32'h0000_0BBB;
        tick();
        is_back = 1'b0;
        pc_valid = 1'b0;
        tick();
        pc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stats_hit_cycle", {31'd0, ins_ready}, 32'd1);
            tick();
        end
        pc_valid = 1'b0;
        #1;
`ifdef INS_CACHE_STATS_EN
        chk("stats_miss_cnt", miss_cnt, 32'd2);
        chk("stats_hit_cnt", hit_cnt, 32'd5);
`else
        chk("stats_miss_cnt", miss_cnt, 32'd0);
        chk("stats_hit_cnt", hit_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
